// File: rtl/mult8x8_seq_core.sv
// Sequential 8x8 unsigned multiplier built from four 4x4 nibble products.
// One partial product is accumulated per cycle (LSB, MID1, MID2, MSB).
// The final sum is published with a single-cycle done pulse.
module mult8x8_seq_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    output logic [15:0] product8x8_out,
    output logic        done_flag,
    output logic        busy,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LSB  = 3'd1,
        MID1 = 3'd2,
        MID2 = 3'd3,
        MSB  = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } opnd_t;

    state_t      state;
    opnd_t       opnd;
    logic [15:0] acc;
    logic [15:0] pp;

    wire [3:0] a_lo = opnd.a[3:0];
    wire [3:0] a_hi = opnd.a[7:4];
    wire [3:0] b_lo = opnd.b[3:0];
    wire [3:0] b_hi = opnd.b[7:4];

    // 4x4 unsigned product, widened first so the full 8-bit result is kept
    function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
        return {4'b0, x} * {4'b0, y};
    endfunction

    assign state_out = state;

    // Select and align the partial product for the current accumulation step
    always_comb begin
        pp = 16'd0;
        case (state)
            LSB:     pp = {8'd0, mul4(a_lo, b_lo)};
            MID1:    pp = {4'd0, mul4(a_hi, b_lo), 4'd0};
            MID2:    pp = {4'd0, mul4(a_lo, b_hi), 4'd0};
            MSB:     pp = {mul4(a_hi, b_hi), 8'd0};
            default: pp = 16'd0;
        endcase
    end

    // Sequencer: operand capture, accumulation and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            opnd           <= '0;
            acc            <= 16'd0;
            product8x8_out <= 16'd0;
            done_flag      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_flag <= 1'b0;
                    if (start) begin
                        opnd.a <= dataa;
                        opnd.b <= datab;
                        acc    <= 16'd0;
                        busy   <= 1'b1;
                        state  <= LSB;
                    end else begin
                        state  <= IDLE;
                    end
                end
                LSB: begin
                    acc   <= acc + pp;
                    state <= MID1;
                end
                MID1: begin
                    acc   <= acc + pp;
                    state <= MID2;
                end
                MID2: begin
                    acc   <= acc + pp;
                    state <= MSB;
                end
                MSB: begin
                    product8x8_out <= acc + pp;
                    done_flag      <= 1'b1;
                    busy           <= 1'b0;
                    state          <= DONE;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult8x8_seq_core.sv
// Directed bench for mult8x8_seq_core: stimulus pushes expected products,
// an independent monitor pops and compares on every done pulse.
module tb_mult8x8_seq_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [15:0] product8x8_out;
    logic        done_flag;
    logic        busy;
    logic [2:0]  state_out;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc[$];
    logic [15:0] expq[$];
    logic        done_d = 1'b0;

    mult8x8_seq_core dut (
        .clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
        .product8x8_out(product8x8_out), .done_flag(done_flag), .busy(busy),
        .state_out(state_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare each published product against the scoreboard head
    always @(negedge clk) begin
        if (done_flag) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (expq.size() == 0) chk("unexpected_done", 1, 0);
            else chk("product", product8x8_out, expq.pop_front());
        end
        if (done_flag && done_d) chk("done_width", 2, 1);
        done_d <= done_flag;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; dataa = 8'd0; datab = 8'd0;
        tick(); tick();
        chk("rst_state", state_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_flag, 0);
        chk("rst_product", product8x8_out, 0);
        reset = 1'b0;
        tick();

        // 1: 10*6, state walk and busy/done timing
        dataa = 8'd10; datab = 8'd6; start = 1'b1; expq.push_back(16'd60);
        tick(); start = 1'b0; dataa = 8'hAA; datab = 8'h55;
        chk("t1_state_e0", state_out, 1);
        chk("t1_busy_e0", busy, 1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("t1_state", state_out, k);
            chk("t1_busy", busy, 1);
        end
        tick();
        chk("t1_state_done", state_out, 5);
        chk("t1_done", done_flag, 1);
        chk("t1_busy_done", busy, 0);
        tick();
        chk("t1_state_idle", state_out, 0);
        chk("t1_done_low", done_flag, 0);
        chk("t1_hold", product8x8_out, 60);
        tick();

        // 2: 255*255 with intermediate accumulator values
        dataa = 8'd255; datab = 8'd255; start = 1'b1; expq.push_back(16'hFE01);
        tick(); start = 1'b0;
        tick(); chk("t2_acc_lsb", dut.acc, 225);
        tick(); chk("t2_acc_mid1", dut.acc, 3825);
        tick(); chk("t2_acc_mid2", dut.acc, 7425);
        tick(); chk("t2_prod", product8x8_out, 65025);
        tick(); tick();

        // 3: back-to-back with start held high
        n = done_cyc.size();
        dataa = 8'd2; datab = 8'd4; start = 1'b1;
        expq.push_back(16'd8); expq.push_back(16'd500);
        tick(); tick(); tick(); tick();
        tick();
        chk("t3_state_done", state_out, 5);
        dataa = 8'd20; datab = 8'd25;
        tick();
        chk("t3_no_idle", state_out, 1);
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("t3_done_count", done_cyc.size() - n, 2);
        if (done_cyc.size() - n == 2)
            chk("t3_spacing", done_cyc[n+1] - done_cyc[n], 5);

        // 4: start during MID1 is ignored
        dataa = 8'd16; datab = 8'd16; start = 1'b1; expq.push_back(16'd256);
        tick(); start = 1'b0;
        tick();
        chk("t4_mid1", state_out, 2);
        dataa = 8'd1; datab = 8'd1; start = 1'b1;
        tick();
        chk("t4_mid2", state_out, 3);
        chk("t4_busy_mid2", busy, 1);
        start = 1'b0;
        tick();
        chk("t4_msb", state_out, 4);
        chk("t4_busy_msb", busy, 1);
        tick();
        chk("t4_prod", product8x8_out, 256);
        tick(); tick();

        // 5: reset during MID2 aborts with no publication
        n = done_cnt;
        dataa = 8'd200; datab = 8'd100; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("t5_mid2", state_out, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_state", state_out, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done_flag, 0);
        chk("t5_prod", product8x8_out, 0);
        for (int k = 0; k < 8; k++) tick();
        chk("t5_no_done", done_cnt - n, 0);

        // 6: zero operand still runs full sequence, then holds
        dataa = 8'd0; datab = 8'd173; start = 1'b1; expq.push_back(16'd0);
        n = done_cnt;
        tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t6_busy", busy, (k < 4) ? 1 : 0);
            tick();
        end
        chk("t6_done", done_flag, 1);
        chk("t6_busy_off", busy, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t6_hold", product8x8_out, 0);
        end
        chk("t6_state", state_out, 0);
        chk("t6_done_count", done_cnt - n, 1);

        chk("scoreboard_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult8x8_seq_core.md
Name: mult8x8_seq_core

Overview:
- Sequential 8x8 unsigned multiplier core. It sits directly upstream of and around the 16-bit adder stage.
- Each operand is split into nibbles. Four 4x4 partial products are formed, shifted by 0/4/4/8 and accumulated one per cycle into a 16-bit register.
- The core delivers the final product with a one-cycle done pulse. It is the block the adder stage consumes from and feeds back into.

Parameters:
None. Operand width is fixed at 8, nibble width at 4 and product width at 16.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when state is IDLE or DONE
dataa  input  8  multiplicand, captured on accepted start
datab  input  8  multiplier, captured on accepted start
product8x8_out  output  16  final product; updated only on completion, held otherwise
done_flag  output  1  high for exactly one cycle when product8x8_out becomes valid
busy  output  1  high while state is in LSB, MID1, MID2 or MSB
state_out  output  3  current state encoding: IDLE=0, LSB=1, MID1=2, MID2=3, MSB=4, DONE=5

Behaviour:
- Reset (synchronous, active-high), sampled at a rising edge:
  - state set to IDLE.
  - acc, the latched operands, product8x8_out, done_flag and busy all set to 0.
  - Reset overrides start and any in-flight operation. A partial result is never published.
- Start acceptance:
  - start is accepted only in IDLE or DONE.
  - On acceptance: a_reg<=dataa, b_reg<=datab, acc<=0, next state LSB.
  - start while busy=1 is ignored. The operands and sequence are unaffected.
- Nibbles: a_lo=a_reg[3:0], a_hi=a_reg[7:4], b_lo=b_reg[3:0], b_hi=b_reg[7:4].
- Each partial product is an 8-bit unsigned 4x4 product, zero-extended to 16 bits before shifting.
- Accumulation sequence, one cycle per state:
  - LSB: acc<=acc+(a_lo*b_lo). Next state MID1.
  - MID1: acc<=acc+((a_hi*b_lo)<<4). Next state MID2.
  - MID2: acc<=acc+((a_lo*b_hi)<<4). Next state MSB.
  - MSB: product8x8_out<=acc+((a_hi*b_hi)<<8), done_flag<=1. Next state DONE.
  - DONE: done_flag<=0. Next state IDLE, or LSB if start=1 (back-to-back operation).
  - IDLE: holds. product8x8_out holds its last value.
- Arithmetic:
  - All sums are 16-bit modulo.
  - The mathematical maximum is 255*255=65025, so no truncation occurs. No carry-out is produced.
- Latency:
  - Start sampled at edge E0.
  - product8x8_out valid and done_flag=1 after edge E4.
  - done_flag is high for the E4->E5 cycle only.
  - Minimum issue interval is 5 cycles, achieved with start held high.
- busy is registered. It is 1 from after E0 through the cycle in MSB, and 0 from DONE onward.
- The dataa and datab inputs may change freely after acceptance. Only the latched copies are used.
- Zero operands are not special-cased. The full 4-cycle sequence still runs.

Test Plan:
1. Reset, then dataa=10, datab=6, start pulse -> after 4 edges product8x8_out=60, done_flag high exactly 1 cycle; state_out sequence 1,2,3,4,5,0.
2. dataa=255, datab=255 -> product8x8_out=65025 (0xFE01); intermediate acc after LSB=225, after MID1=3825, after MID2=7425.
3. start held high continuously with dataa=2, datab=4, then dataa=20, datab=25 presented on the DONE cycle -> results 8 then 500, done_flag pulses 5 cycles apart, no IDLE cycle in between.
4. start re-asserted with dataa=1, datab=1 during MID1 of a 16x16 operation -> ignored; product8x8_out=256, busy stays high through MSB.
5. reset asserted during MID2 of 200x100 -> next cycle state_out=0, busy=0, done_flag=0, product8x8_out=0; no done pulse follows.
6. dataa=0, datab=173 -> still 4 busy cycles, product8x8_out=0, done_flag pulses; product then held through 10 idle cycles.
